// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from instruction memory, buffers {pc, instr}
// pairs in a small FIFO for decode, and handles redirects and sticky fetch faults.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MEM_WORDS    = 1024,
  parameter int          QDEPTH       = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int          PW    = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;
  localparam int          CW    = $clog2(QDEPTH + 1);
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic {RUN, FAULT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  state_e                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic                    fault_q, fault_d;
  logic [31:0]             faddr_q, faddr_d;
  fq_entry_t [QDEPTH-1:0]  fq_q;
  logic [PW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           count_q;

  logic deq, space, enq, flush, bad_pc, bad_rd;

  assign deq    = if_valid & id_ready;
  assign space  = (count_q < CW'(QDEPTH)) | deq;
  assign bad_pc = (pc_q[1:0] != 2'b00) | ({1'b0, pc_q} >= LIMIT);
  assign bad_rd = (redirect_pc[1:0] != 2'b00) | ({1'b0, redirect_pc} >= LIMIT);

  // Redirect outranks fetch; fault state is only left by redirect or reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    faddr_d = faddr_q;
    enq     = 1'b0;
    flush   = 1'b0;
    if (redirect) begin
      flush = 1'b1;
      pc_d  = redirect_pc;
      if (bad_rd) begin
        state_d = FAULT;
        fault_d = 1'b1;
        faddr_d = redirect_pc;
      end else begin
        state_d = RUN;
        fault_d = 1'b0;
        faddr_d = 32'h0;
      end
    end else if (state_q == RUN && space) begin
      if (bad_pc) begin
        state_d = FAULT;
        fault_d = 1'b1;
        faddr_d = pc_q;
      end else begin
        enq  = 1'b1;
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      fault_q <= 1'b0;
      faddr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
    end
  end

  // Flush drops everything, including an entry dequeued in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fq_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        fq_q[wr_q] <= '{pc: pc_q, instr: imem_instr};
        wr_q       <= (wr_q == PW'(QDEPTH - 1)) ? '0 : wr_q + PW'(1);
      end
      if (deq)
        rd_q <= (rd_q == PW'(QDEPTH - 1)) ? '0 : rd_q + PW'(1);
      count_q <= count_q + CW'(enq) - CW'(deq);
    end
  end

  assign imem_addr  = pc_q;
  assign if_valid   = (count_q != '0);
  assign if_instr   = fq_q[rd_q].instr;
  assign if_pc      = fq_q[rd_q].pc;
  assign fault      = fault_q;
  assign fault_addr = faddr_q;

endmodule
